// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO built from a simple dual-port RAM with a registered read,
// followed by a 2-entry prefetch stage (head + skid). The prefetch keeps one word per cycle
// flowing regardless of when the consumer reads.
//
// Ports:
//   clk, rst_n          clock (rising edge) and asynchronous active-low reset
//   flush               synchronous clear of all contents
//   s_valid/s_ready     write handshake, s_data write data
//   m_valid/m_ready     read handshake, m_data head word
//   fifo_level          words held (RAM + read pipeline + prefetch), 0..FIFO_DEPTH
//   fifo_empty/full     level == 0 / level == FIFO_DEPTH
//   fifo_afull/aempty   level >= AFULL_THRESH / level <= AEMPTY_THRESH
module fifo_fwft #(
    parameter int FIFO_DEPTH    = 128,
    parameter int FIFO_WIDTH    = 24,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 4,
    parameter int AEMPTY_THRESH = 4,
    localparam int CW           = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FIFO_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic [CW:0]           fifo_level,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  fifo_afull,
    output logic                  fifo_aempty
);

    localparam logic [CW:0] DepthLvl  = (CW + 1)'(FIFO_DEPTH);
    localparam logic [CW:0] AfullLvl  = (CW + 1)'(AFULL_THRESH);
    localparam logic [CW:0] AemptyLvl = (CW + 1)'(AEMPTY_THRESH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [FIFO_WIDTH-1:0] ram_q;

    logic [CW:0]           wr_ptr_q, rd_ptr_q, level_q, level_d;
    logic [FIFO_WIDTH-1:0] head_q, head_d, skid_q, skid_d;
    logic                  head_vld_q, head_vld_d, skid_vld_q, skid_vld_d;
    logic                  rd_pend_q;

    logic                  wr_fire, rd_fire, ram_has, ram_rd;
    logic [1:0]            occ_after;

    assign s_ready = ~fifo_full & ~flush;
    assign m_valid = head_vld_q & ~flush;
    assign m_data  = head_q;

    assign wr_fire = s_valid & s_ready;
    assign rd_fire = m_valid & m_ready;

    // Committed words still sitting in RAM; the MSB separates full from empty.
    assign ram_has = (wr_ptr_q != rd_ptr_q);

    // Prefetch entries plus the in-flight read, after this cycle's pop.
    assign occ_after = {1'b0, head_vld_q} + {1'b0, skid_vld_q} + {1'b0, rd_pend_q}
                     - {1'b0, rd_fire};
    assign ram_rd    = ram_has & (occ_after < 2'd2) & ~flush;

    // Prefetch next state: pop first, then land returning RAM data behind whatever remains.
    always_comb begin
        head_d     = head_q;
        skid_d     = skid_q;
        head_vld_d = head_vld_q;
        skid_vld_d = skid_vld_q;
        if (rd_fire) begin
            if (skid_vld_q) begin
                head_d     = skid_q;
                skid_vld_d = 1'b0;
            end else begin
                head_vld_d = 1'b0;
            end
        end
        if (rd_pend_q) begin
            if (!head_vld_d) begin
                head_d     = ram_q;
                head_vld_d = 1'b1;
            end else begin
                skid_d     = ram_q;
                skid_vld_d = 1'b1;
            end
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_q     <= '0;
            skid_q     <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else if (flush) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            head_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rd_pend_q  <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (ram_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            level_q    <= level_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            head_vld_q <= head_vld_d;
            skid_vld_q <= skid_vld_d;
            rd_pend_q  <= ram_rd;
        end
    end

    // Storage has no reset; ram_q is only consumed when rd_pend_q says it is valid.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q[CW-1:0]] <= s_data;
        end
        if (ram_rd) begin
            ram_q <= mem[rd_ptr_q[CW-1:0]];
        end
    end

    assign fifo_level  = level_q;
    assign fifo_empty  = (level_q == '0);
    assign fifo_full   = (level_q == DepthLvl);
    assign fifo_afull  = (level_q >= AfullLvl);
    assign fifo_aempty = (level_q <= AemptyLvl);

endmodule

// File: tb/tb_fifo_fwft.sv
module tb_fifo_fwft;

    localparam int DEPTH = 128;
    localparam int W     = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [W-1:0]  s_data;
    logic          m_valid;
    logic          m_ready;
    logic [W-1:0]  m_data;
    logic [7:0]    fifo_level;
    logic          fifo_empty, fifo_full, fifo_afull, fifo_aempty;

    fifo_fwft #(
        .FIFO_DEPTH   (DEPTH),
        .FIFO_WIDTH   (W),
        .AFULL_THRESH (DEPTH - 4),
        .AEMPTY_THRESH(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .fifo_level (fifo_level),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .fifo_afull (fifo_afull),
        .fifo_aempty(fifo_aempty)
    );

    always #5 clk = ~clk;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [W-1:0] sb [$];

    // Per-cycle observations, sampled at the falling edge.
    bit           obs_wr, obs_rd, obs_mv, obs_sready, obs_empty, obs_full, obs_afull, obs_aempty;
    logic [W-1:0] obs_md;
    logic [7:0]   obs_lvl;

    // Sample one cycle of DUT state, record accepted writes in the scoreboard,
    // then return just after the next rising edge so stimulus can change.
    task automatic cycle();
        @(negedge clk);
        obs_sready = s_ready;
        obs_mv     = m_valid;
        obs_md     = m_data;
        obs_lvl    = fifo_level;
        obs_empty  = fifo_empty;
        obs_full   = fifo_full;
        obs_afull  = fifo_afull;
        obs_aempty = fifo_aempty;
        obs_wr     = s_valid && s_ready;
        obs_rd     = m_valid && m_ready;
        if (obs_wr) sb.push_back(s_data);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (fifo_level !== 8'd0) begin failures++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_mvalid got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin failures++; $display("FAIL reset_mdata got %h want 0", m_data); end
        checks++; if ({fifo_empty, fifo_full, fifo_aempty, fifo_afull} !== 4'b1010) begin
            failures++; $display("FAIL reset_flags got %b want 1010", {fifo_empty, fifo_full, fifo_aempty, fifo_afull});
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle();
        checks++; if (obs_sready !== 1'b1) begin failures++; $display("FAIL reset_sready got %b want 1", obs_sready); end
        checks++; if (obs_lvl !== 8'd0) begin failures++; $display("FAIL post_reset_level got %0d want 0", obs_lvl); end
    endtask

    task automatic test_fill();
        int acc = 0;
        int first_af = -1;
        int bad_af = 0;
        int bad_lvl = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int n = 0; n < 300 && acc < DEPTH; n++) begin
            s_data = W'(acc + 1);
            cycle();
            if (obs_lvl !== 8'(acc)) bad_lvl++;
            if (obs_afull !== (acc >= DEPTH - 4)) bad_af++;
            if (obs_afull && first_af < 0) first_af = acc;
            if (obs_wr) acc++;
        end
        checks++; if (acc !== DEPTH) begin failures++; $display("FAIL fill_accepts got %0d want %0d", acc, DEPTH); end
        checks++; if (bad_lvl !== 0) begin failures++; $display("FAIL fill_level_track got %0d bad want 0", bad_lvl); end
        checks++; if (bad_af !== 0) begin failures++; $display("FAIL fill_afull_track got %0d bad want 0", bad_af); end
        checks++; if (first_af !== DEPTH - 4) begin failures++; $display("FAIL fill_afull_first got %0d want %0d", first_af, DEPTH - 4); end
        s_data = W'(DEPTH + 1);
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++; if (obs_wr !== 1'b0 || obs_sready !== 1'b0) begin
                failures++; $display("FAIL fill_hold got wr=%b sready=%b want 0 0", obs_wr, obs_sready);
            end
            checks++; if (obs_lvl !== 8'(DEPTH) || obs_full !== 1'b1) begin
                failures++; $display("FAIL fill_full got lvl=%0d full=%b want %0d 1", obs_lvl, obs_full, DEPTH);
            end
        end
    endtask

    task automatic test_boundary();
        logic [W-1:0] exp;
        int guard = 0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        cycle();
        checks++; if (obs_rd !== 1'b1 || obs_wr !== 1'b0) begin
            failures++; $display("FAIL bound_rw got rd=%b wr=%b want 1 0", obs_rd, obs_wr);
        end
        if (obs_rd) begin
            exp = sb.pop_front();
            checks++; if (obs_md !== exp) begin failures++; $display("FAIL bound_data got %h want %h", obs_md, exp); end
        end
        m_ready = 1'b0;
        cycle();
        checks++; if (obs_lvl !== 8'(DEPTH - 1) || obs_wr !== 1'b1) begin
            failures++; $display("FAIL bound_127 got lvl=%0d wr=%b want 127 1", obs_lvl, obs_wr);
        end
        s_valid = 1'b0;
        cycle();
        checks++; if (obs_lvl !== 8'(DEPTH)) begin failures++; $display("FAIL bound_back got %0d want %0d", obs_lvl, DEPTH); end
        m_ready = 1'b1;
        while (sb.size() > 0 && guard < 400) begin
            cycle();
            guard++;
            if (obs_rd) begin
                exp = sb.pop_front();
                checks++; if (obs_md !== exp) begin failures++; $display("FAIL drain_data got %h want %h", obs_md, exp); end
            end
        end
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL drain_timeout got %0d left want 0", sb.size()); end
        cycle();
        checks++; if (obs_empty !== 1'b1 || obs_mv !== 1'b0) begin
            failures++; $display("FAIL drain_empty got empty=%b mv=%b want 1 0", obs_empty, obs_mv);
        end
    endtask

    task automatic test_fall_through();
        int first = -1;
        logic [W-1:0] exp;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 24'hABCDEF;
        cycle();
        s_valid = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (obs_mv && first < 0) begin
                first = k;
                exp = sb[0];
                checks++; if (obs_md !== exp) begin failures++; $display("FAIL ft_data got %h want %h", obs_md, exp); end
            end
            checks++; if (obs_aempty !== 1'b1) begin failures++; $display("FAIL ft_aempty got %b want 1", obs_aempty); end
        end
        checks++; if (first !== 3) begin failures++; $display("FAIL ft_latency got %0d want 3", first); end
        m_ready = 1'b1;
        cycle();
        if (obs_rd) void'(sb.pop_front());
        m_ready = 1'b0;
        checks++; if (sb.size() !== 0) begin failures++; $display("FAIL ft_pop got %0d left want 0", sb.size()); end
    endtask

    task automatic test_stream();
        int sent = 0;
        int guard = 0;
        int bubbles = 0;
        int bad_lvl = 0;
        int bad_data = 0;
        int got = 0;
        bit seen = 0;
        bit writing;
        logic [W-1:0] exp;
        m_ready = 1'b1;
        while ((sent < 1000 || sb.size() > 0) && guard < 3000) begin
            writing = (sent < 1000);
            s_valid = writing;
            s_data  = W'(24'h100000 + sent);
            cycle();
            guard++;
            if (seen && writing && !obs_rd) bubbles++;
            if (sent >= 10 && sent < 990 && obs_lvl !== 8'd3) bad_lvl++;
            if (obs_wr) sent++;
            if (obs_rd) begin
                seen = 1;
                got++;
                exp = sb.pop_front();
                if (obs_md !== exp) bad_data++;
            end
        end
        s_valid = 1'b0;
        checks++; if (got !== 1000) begin failures++; $display("FAIL stream_count got %0d want 1000", got); end
        checks++; if (bad_data !== 0) begin failures++; $display("FAIL stream_order got %0d bad want 0", bad_data); end
        checks++; if (bubbles !== 0) begin failures++; $display("FAIL stream_bubbles got %0d want 0", bubbles); end
        checks++; if (bad_lvl !== 0) begin failures++; $display("FAIL stream_level got %0d bad want 0", bad_lvl); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int guard = 0;
        int got = 0;
        int bad_data = 0;
        int bad_hold = 0;
        bit stalled = 0;
        logic [W-1:0] held = '0;
        logic [W-1:0] exp;
        while ((sent < 500 || sb.size() > 0) && guard < 5000) begin
            s_valid = (sent < 500);
            s_data  = W'(24'h200000 + sent);
            m_ready = ($urandom_range(0, 99) < 30);
            cycle();
            guard++;
            if (stalled && obs_mv && obs_md !== held) bad_hold++;
            stalled = obs_mv && !obs_rd;
            held    = obs_md;
            if (obs_wr) sent++;
            if (obs_rd) begin
                got++;
                exp = sb.pop_front();
                if (obs_md !== exp) bad_data++;
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        checks++; if (got !== 500) begin failures++; $display("FAIL bp_count got %0d want 500", got); end
        checks++; if (bad_data !== 0) begin failures++; $display("FAIL bp_order got %0d bad want 0", bad_data); end
        checks++; if (bad_hold !== 0) begin failures++; $display("FAIL bp_stable got %0d bad want 0", bad_hold); end
    endtask

    task automatic test_clear(input bit use_reset);
        int guard = 0;
        bit got = 0;
        logic [W-1:0] exp;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            s_data = W'(24'h300000 + i);
            cycle();
        end
        s_valid = 1'b0;
        cycle();
        checks++; if (obs_lvl !== 8'd50) begin failures++; $display("FAIL clr_pre_level got %0d want 50", obs_lvl); end
        if (use_reset) begin
            rst_n = 1'b0;
            #2;
            checks++; if (fifo_level !== 8'd0 || m_valid !== 1'b0) begin
                failures++; $display("FAIL rst_async got lvl=%0d mv=%b want 0 0", fifo_level, m_valid);
            end
            @(posedge clk);
            #1 rst_n = 1'b1;
        end else begin
            flush   = 1'b1;
            s_valid = 1'b1;
            s_data  = 24'hDEAD00;
            m_ready = 1'b1;
            cycle();
            checks++; if (obs_sready !== 1'b0 || obs_mv !== 1'b0) begin
                failures++; $display("FAIL flush_cycle got sready=%b mv=%b want 0 0", obs_sready, obs_mv);
            end
            flush   = 1'b0;
            s_valid = 1'b0;
            m_ready = 1'b0;
        end
        sb.delete();
        cycle();
        checks++; if (obs_lvl !== 8'd0 || obs_mv !== 1'b0 || obs_empty !== 1'b1) begin
            failures++; $display("FAIL clr_after got lvl=%0d mv=%b empty=%b want 0 0 1", obs_lvl, obs_mv, obs_empty);
        end
        s_valid = 1'b1;
        s_data  = 24'h123456;
        cycle();
        s_valid = 1'b0;
        m_ready = 1'b1;
        while (!got && guard < 10) begin
            cycle();
            guard++;
            if (obs_rd) begin
                got = 1;
                exp = (sb.size() > 0) ? sb.pop_front() : 24'hFFFFFF;
                checks++; if (obs_md !== exp || exp !== 24'h123456) begin
                    failures++; $display("FAIL clr_first got %h want 123456", obs_md);
                end
            end
        end
        checks++; if (!got) begin failures++; $display("FAIL clr_timeout got none want 123456"); end
        m_ready = 1'b0;
        cycle();
        checks++; if (obs_empty !== 1'b1) begin failures++; $display("FAIL clr_empty got %b want 1", obs_empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_boundary();
        test_fall_through();
        test_stream();
        test_backpressure();
        test_clear(1'b0);
        test_clear(1'b1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
